// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state codes, data width and default line settings.
// The receive path imports this same package so both ends agree on frame format.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_START  = 3'b001,
    ST_DATA   = 3'b010,
    ST_PARITY = 3'b011,
    ST_STOP   = 3'b100
  } state_t;

  localparam int UART_DATA_BITS   = 8;
  localparam int DEFAULT_CLK_FREQ = 50_000_000;
  localparam int DEFAULT_BAUD     = 115_200;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, held at 0 otherwise,
// and pulses tick in the last cycle of each bit period.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per handshake, LSB first, 8N1 frame on tx.
// Defining UART_TX_PARITY_EN adds an even-parity bit (8E1, 11 bit periods).
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
  parameter int BAUD     = DEFAULT_BAUD
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tx_start,
  input  logic [UART_DATA_BITS-1:0] tx_data,
  output logic                      tx,
  output logic                      tx_busy,
  output logic                      tx_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  state_t                    state, state_next;
  logic [UART_DATA_BITS-1:0] shreg, shreg_next;
  logic [2:0]                bit_cnt, bit_cnt_next;
  logic                      tick;
  logic                      tx_next, busy_next, done_next;

`ifdef UART_TX_PARITY_EN
  logic parity, parity_next;
`endif

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .en  (state != ST_IDLE),
    .tick(tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      shreg   <= shreg_next;
      bit_cnt <= bit_cnt_next;
      tx      <= tx_next;
      tx_busy <= busy_next;
      tx_done <= done_next;
`ifdef UART_TX_PARITY_EN
      parity  <= parity_next;
`endif
    end
  end

  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    bit_cnt_next = bit_cnt;
    done_next    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next  = parity;
`endif
    case (state)
      ST_IDLE: begin
        if (tx_start) begin
          state_next   = ST_START;
          shreg_next   = tx_data;
          bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
          parity_next  = ^tx_data;
`endif
        end
      end
      ST_START: begin
        if (tick) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          shreg_next   = {1'b0, shreg[UART_DATA_BITS-1:1]};
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_next = ST_PARITY;
`else
            state_next = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) state_next = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (tick) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Line level is derived from the upcoming state so tx stays a plain register.
  always_comb begin
    tx_next   = 1'b1;
    busy_next = (state_next != ST_IDLE);
    case (state_next)
      ST_START: tx_next = 1'b0;
      ST_DATA:  tx_next = shreg_next[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_next = parity_next;
`endif
      default:  tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at CLKS_PER_BIT=16: directed and random frames checked cycle by
// cycle against a bit-list model, plus a behavioural mid-bit sampling receiver.
module tb_uart_tx;
  import uart_tx_pkg::*;

  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx, tx_busy, tx_done;

  int checks = 0;
  int failures = 0;

  logic [8:0] rx_q[$];
  logic [7:0] rx_v;
  logic       rx_ok;

  uart_tx #(
    .CLK_FREQ(160),
    .BAUD    (10)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit idx of the frame: start, 8 data bits LSB first, [even parity], stop.
  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Behavioural receiver: detect start, sample at mid-bit.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx === 1'b0) begin
        repeat (CPB/2) @(negedge clk);
        rx_ok = (tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          rx_v[i] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        rx_ok = rx_ok && (tx === ^rx_v);
`endif
        repeat (CPB) @(negedge clk);
        rx_ok = rx_ok && (tx === 1'b1);
        rx_q.push_back({rx_ok, rx_v});
      end
    end
  end

  // Called at a negedge where the DUT is able to accept.
  task automatic launch(input logic [7:0] b);
    tx_start = 1'b1;
    tx_data  = b;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Entered at the first start-bit cycle; returns at the negedge of the done cycle.
  task automatic run_frame(input logic [7:0] b, input int poke_at, input logic [7:0] poke_data);
    for (int k = 0; k < FRAME; k++) begin
      check($sformatf("tx[%02h] cyc %0d", b, k), tx, exp_bit(b, k / CPB));
      check("busy_in_frame", tx_busy, 1);
      check("done_in_frame", tx_done, 0);
      if (k == poke_at) begin
        tx_start = 1'b1;
        tx_data  = poke_data;
      end else begin
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
      end
      @(negedge clk);
    end
    tx_start = 1'b0;
    check("done_pulse", tx_done, 1);
    check("busy_at_done", tx_busy, 0);
    check("tx_at_done", tx, 1);
    check("rx_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check($sformatf("rx_byte %02h", b), rx_q.pop_front(), {1'b1, b});
    $display("frame data=%02h poke_at=%0d checks=%0d failures=%0d", b, poke_at, checks, failures);
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, "_done"}, tx_done, 0);
    check({tag, "_busy"}, tx_busy, 0);
    check({tag, "_tx"}, tx, 1);
  endtask

  initial begin
    logic [7:0] b;
    int gap, poke;
    bit chain;

    // Reset state, with a request held during reset.
    tx_start = 1'b1;
    tx_data  = 8'hA5;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    tx_start = 1'b0;
    rst = 1'b1;
    idle_check("post_rst");

    // Directed single byte.
    launch(8'hA5);
    run_frame(8'hA5, -1, 8'h00);
    idle_check("after_a5");

    // Request while busy must be dropped.
    launch(8'h81);
    run_frame(8'h81, 50, 8'h3C);
    repeat (CPB + 4) idle_check("after_81");

    // Back-to-back: second request in the done cycle.
    launch(8'h00);
    run_frame(8'h00, -1, 8'h00);
    launch(8'hFF);
    run_frame(8'hFF, -1, 8'h00);
    idle_check("after_ff");

    // Parity-relevant bytes.
    launch(8'h07);
    run_frame(8'h07, -1, 8'h00);
    idle_check("after_07");
    launch(8'h03);
    run_frame(8'h03, -1, 8'h00);
    idle_check("after_03");

    // Reset in the middle of the data bits.
    launch(8'hC3);
    repeat (CPB + 3*CPB + 5) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_tx", tx, 1);
    check("midrst_busy", tx_busy, 0);
    check("midrst_done", tx_done, 0);
    repeat (3) begin
      @(negedge clk);
      check("inrst_tx", tx, 1);
      check("inrst_done", tx_done, 0);
    end
    rst = 1'b1;
    repeat (FRAME + 20) begin
      @(negedge clk);
      check("postabort_done", tx_done, 0);
      check("postabort_busy", tx_busy, 0);
    end
    rx_q.delete();

    // Loopback after reset.
    launch(8'h5A);
    run_frame(8'h5A, -1, 8'h00);
    idle_check("after_5a");

    // Random bytes, random gaps, random busy pokes, random chaining.
    chain = 1'b0;
    for (int i = 0; i < 14; i++) begin
      b = 8'($urandom);
      if (!chain) begin
        gap = $urandom_range(0, 5);
        repeat (gap) idle_check("gap");
      end
      poke = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, FRAME - 1)) : -1;
      launch(b);
      run_frame(b, poke, 8'($urandom));
      chain = ($urandom_range(0, 1) == 1);
      if (!chain) idle_check("rand_end");
    end
    if (chain) idle_check("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
